// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-holding arbiter sharing one FIFO write port between two producers.
// Optional per-producer accepted-beat counters (cnt0/cnt1) are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic [1:0]            grant,
  output logic [1:0]            fsm_state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1
`endif
);

  // Handshake: a word moves on a cycle where reqN_valid and reqN_ready are both 1;
  // ready is only ever raised for the current owner, and it never depends on a future cycle.

  localparam int BCW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [BCW-1:0]   beat_cnt, beat_next, beat_inc;
  logic             last_owner, last_next;
  logic             owner_valid, other_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic             beat, burst_done, release_now;

  assign fsm_state = state;
  assign beat_inc  = beat_cnt + 1'b1;

  always_comb begin
    owner_valid  = 1'b0;
    other_valid  = 1'b0;
    owner_data   = '0;
    unique case (state)
      OWN0: begin
        owner_valid = req0_valid;
        other_valid = req1_valid;
        owner_data  = req0_data;
      end
      OWN1: begin
        owner_valid = req1_valid;
        other_valid = req0_valid;
        owner_data  = req1_data;
      end
      default: ;
    endcase

    // rst gates the write path combinationally so nothing leaks out during reset
    beat         = !rst && (state != IDLE) && owner_valid && !fifo_full;
    fifo_wr_en   = beat;
    req0_ready   = beat && (state == OWN0);
    req1_ready   = beat && (state == OWN1);
    fifo_data_in = beat ? owner_data : '0;

    burst_done   = beat && (beat_inc == BCW'(BURST_LEN));
    release_now  = (state != IDLE) && (!owner_valid || burst_done);
  end

  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    last_next  = last_owner;
    unique case (state)
      IDLE: begin
        if (req0_valid && req1_valid)
          state_next = last_owner ? OWN0 : OWN1;
        else if (req0_valid)
          state_next = OWN0;
        else if (req1_valid)
          state_next = OWN1;
      end
      OWN0, OWN1: begin
        if (release_now) begin
          last_next = (state == OWN1);
          beat_next = '0;
          // Prefer the other producer, then a fresh burst for the same one
          if (other_valid)
            state_next = (state == OWN0) ? OWN1 : OWN0;
          else if (owner_valid)
            state_next = state;
          else
            state_next = IDLE;
        end else if (beat) begin
          beat_next = beat_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      beat_cnt   <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      beat_cnt   <= beat_next;
      last_owner <= last_next;
      unique case (state_next)
        OWN0:    grant <= 2'b01;
        OWN1:    grant <= 2'b10;
        default: grant <= 2'b00;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating counters: stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (req0_ready && (cnt0 != {CNT_WIDTH{1'b1}}))
        cnt0 <= cnt0 + 1'b1;
      if (req1_ready && (cnt1 != {CNT_WIDTH{1'b1}}))
        cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference of the arbitration rules.
module tb_fifo_write_arbiter;

  localparam int DW = 8;
  localparam int BL = 4;
`ifdef FIFO_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant;
  logic [1:0]    fsm_state;
`ifdef FIFO_ARB_STATS_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  fifo_write_arbiter #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant        (grant),
    .fsm_state    (fsm_state)
`ifdef FIFO_ARB_STATS_EN
    ,
    .cnt0         (cnt0),
    .cnt1         (cnt1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src0[$];
  logic [DW-1:0] src1[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_log[$];
  int            wr_cyc[$];
  bit            en0, en1;
  int            cyc;

  // reference state: owner -1 = nobody, 0/1 = producer index
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = 1;
  int m_cnt0  = 0;
  int m_cnt1  = 0;

  logic       s_wr, s_r0, s_r1;
  logic [1:0] s_grant;

  // one clock cycle: drive at negedge, compare, then advance producers and the reference
  task automatic cycle(input bit r, input bit full);
    bit            v0, v1, e_wr, e_r0, e_r1, rel;
    logic [DW-1:0] e_data, got;
    logic [1:0]    e_grant;
    @(negedge clk);
    v0 = en0 && (src0.size() > 0);
    v1 = en1 && (src1.size() > 0);
    rst        = r;
    fifo_full  = full;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = v0 ? src0[0] : DW'($urandom);
    req1_data  = v1 ? src1[0] : DW'($urandom);
    #1;
    e_wr    = !r && (m_owner >= 0) && ((m_owner == 0) ? v0 : v1) && !full;
    e_r0    = e_wr && (m_owner == 0);
    e_r1    = e_wr && (m_owner == 1);
    e_data  = e_wr ? ((m_owner == 0) ? src0[0] : src1[0]) : '0;
    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;

    checks++;
    if (grant !== e_grant) begin
      failures++;
      $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant);
    end
    checks++;
    if (fifo_wr_en !== e_wr) begin
      failures++;
      $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, e_wr);
    end
    checks++;
    if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
      failures++;
      $display("FAIL ready cyc=%0d got=%b%b exp=%b%b", cyc, req1_ready, req0_ready, e_r1, e_r0);
    end
    checks++;
    if (fifo_data_in !== e_data) begin
      failures++;
      $display("FAIL data_in cyc=%0d got=%h exp=%h", cyc, fifo_data_in, e_data);
    end
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (cnt0 !== CW'(m_cnt0) || cnt1 !== CW'(m_cnt1)) begin
      failures++;
      $display("FAIL stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, cnt0, cnt1, m_cnt0, m_cnt1);
    end
`endif

    // scoreboard on what actually reaches the FIFO
    if (e_wr) exp_q.push_back(e_data);
    if (fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected cyc=%0d got=%h exp=none", cyc, fifo_data_in);
      end else begin
        got = exp_q.pop_front();
        if (fifo_data_in !== got) begin
          failures++;
          $display("FAIL sb_order cyc=%0d got=%h exp=%h", cyc, fifo_data_in, got);
        end
      end
      wr_log.push_back(fifo_data_in);
      wr_cyc.push_back(cyc);
    end

    s_wr = fifo_wr_en; s_r0 = req0_ready; s_r1 = req1_ready; s_grant = grant;

    if (req0_ready === 1'b1 && src0.size() > 0 && v0) void'(src0.pop_front());
    if (req1_ready === 1'b1 && src1.size() > 0 && v1) void'(src1.pop_front());

    if (r) begin
      m_owner = -1; m_beats = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      if (e_r0 && m_cnt0 < (1 << CW) - 1) m_cnt0++;
      if (e_r1 && m_cnt1 < (1 << CW) - 1) m_cnt1++;
      if (m_owner < 0) begin
        if (v0 && v1)  m_owner = 1 - m_last;
        else if (v0)   m_owner = 0;
        else if (v1)   m_owner = 1;
      end else begin
        if (e_wr) m_beats++;
        rel = !((m_owner == 0) ? v0 : v1) || (m_beats == BL);
        if (rel) begin
          m_last  = m_owner;
          m_beats = 0;
          if ((m_owner == 0) ? v1 : v0)      m_owner = 1 - m_owner;
          else if (!((m_owner == 0) ? v0 : v1)) m_owner = -1;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    src0.delete(); src1.delete();
    en0 = 0; en1 = 0;
    cycle(1, 0);
    cycle(1, 0);
    wr_log.delete(); wr_cyc.delete();
  endtask

  task automatic test_reset();
    en0 = 1; en1 = 1;
    src0.push_back(8'h11); src1.push_back(8'h22);
    cycle(1, 0);
    cycle(1, 0);
    en0 = 0; en1 = 0;
    cycle(0, 0);
    checks++;
    if (s_grant !== 2'b00 || s_wr !== 1'b0 || s_r0 !== 1'b0 || s_r1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b/%b/%b%b exp=00/0/00", s_grant, s_wr, s_r1, s_r0);
    end
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
    end
`endif
  endtask

  task automatic test_single_producer();
    logic [1:0] g1;
    do_reset();
    for (int i = 0; i < 6; i++) src0.push_back(8'hA1 + DW'(i));
    en0 = 1;
    cycle(0, 0);
    cycle(0, 0);
    g1 = s_grant;
    for (int i = 0; i < 7; i++) cycle(0, 0);
    checks++;
    if (g1 !== 2'b01) begin
      failures++;
      $display("FAIL single_grant got=%b exp=01", g1);
    end
    checks++;
    if (wr_log.size() != 6) begin
      failures++;
      $display("FAIL single_count got=%0d exp=6", wr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_log[i] !== 8'hA1 + DW'(i)) begin
          failures++;
          $display("FAIL single_word%0d got=%h exp=%h", i, wr_log[i], 8'hA1 + DW'(i));
        end
      end
    end
    checks++;
    if (s_grant !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got=%b exp=00", s_grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    int blk;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      src0.push_back(8'h10 + DW'(i));
      src1.push_back(8'h90 + DW'(i));
    end
    en0 = 1; en1 = 1;
    for (int i = 0; i < 14; i++) cycle(0, 0);
    checks++;
    if (wr_log.size() < 12) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp>=12", wr_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        blk = k / 4;
        e = ((blk % 2) == 0) ? 8'h10 + DW'((blk / 2) * 4 + k % 4) : 8'h90 + DW'((blk / 2) * 4 + k % 4);
        checks++;
        if (wr_log[k] !== e) begin
          failures++;
          $display("FAIL b2b_word%0d got=%h exp=%h", k, wr_log[k], e);
        end
      end
      checks++;
      if (wr_cyc[11] - wr_cyc[0] != 11) begin
        failures++;
        $display("FAIL b2b_gap got=%0d exp=11", wr_cyc[11] - wr_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] e [5];
    e[0] = 8'hB0; e[1] = 8'hB1; e[2] = 8'hB2; e[3] = 8'hB3; e[4] = 8'hC0;
    do_reset();
    for (int i = 0; i < 8; i++) src1.push_back(8'hB0 + DW'(i));
    for (int i = 0; i < 4; i++) src0.push_back(8'hC0 + DW'(i));
    en1 = 1;
    for (int i = 0; i < 3; i++) cycle(0, 0);
    en0 = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1);
      checks++;
      if (s_wr !== 1'b0 || s_r1 !== 1'b0 || s_grant !== 2'b10) begin
        failures++;
        $display("FAIL stall%0d got=wr%b rdy%b g%b exp=wr0 rdy0 g10", i, s_wr, s_r1, s_grant);
      end
    end
    for (int i = 0; i < 4; i++) cycle(0, 0);
    checks++;
    if (wr_log.size() < 5) begin
      failures++;
      $display("FAIL stall_count got=%0d exp>=5", wr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_log[i] !== e[i]) begin
          failures++;
          $display("FAIL stall_word%0d got=%h exp=%h", i, wr_log[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 6; i++) src1.push_back(8'hD0 + DW'(i));
    en1 = 1;
    for (int i = 0; i < 3; i++) cycle(0, 0);
    for (int i = 0; i < 4; i++) src0.push_back(8'hE0 + DW'(i));
    en0 = 1;
    cycle(1, 0);
    checks++;
    if (s_wr !== 1'b0 || s_r1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_gate got=wr%b rdy%b exp=wr0 rdy0", s_wr, s_r1);
    end
    cycle(0, 0);
    checks++;
    if (s_grant !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_grant got=%b exp=00", s_grant);
    end
    cycle(0, 0);
    checks++;
    if (s_grant !== 2'b01 || s_wr !== 1'b1 || wr_log[wr_log.size()-1] !== 8'hE0) begin
      failures++;
      $display("FAIL rst_mid_first got=g%b wr%b d%h exp=g01 wr1 dE0", s_grant, s_wr, wr_log[wr_log.size()-1]);
    end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) src0.push_back(8'h50 + DW'(i));
    en0 = 1;
    for (int i = 0; i < 8; i++) cycle(0, 0);
    checks++;
    if (cnt0 !== CW'(3) || cnt1 !== CW'(0)) begin
      failures++;
      $display("FAIL stats_sat got=%0d/%0d exp=3/0", cnt0, cnt1);
    end
  endtask
`endif

  task automatic test_random();
    bit r, full;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (src0.size() < 3) src0.push_back(DW'($urandom));
      if (src1.size() < 3) src1.push_back(DW'($urandom));
      en0  = ($urandom_range(0, 3) != 0);
      en1  = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 99) == 0);
      cycle(r, full);
    end
  endtask

  initial begin
    rst = 1'b1; fifo_full = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    en0 = 0; en1 = 0; cyc = 0;
    test_reset();
    test_single_producer();
    test_back_to_back();
    test_stall();
    test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
